keypad_entry: RTL
=================

# keypad_entry

Input-side companion to the seven-segment display path. The block scans a 4x4 hex matrix keypad and debounces key presses. It shifts each accepted hex digit into a 32-bit entry register, whose value feeds the processor input port and the seven-segment display `out` bus for echo. One accepted key press inserts exactly one nibble, regardless of how long the key is held.

## Interface
Parameters:
- `SCAN_BITS`, default 16: prescaler width; column dwell = 2^SCAN_BITS clk1 cycles.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full-scan frames needed to accept a press or a release; legal range 1..15.

Ports:
- `clk1`  in  1: single system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `row`  in  4: keypad rows, active-low, externally pulled up; asynchronous to clk1.
- `col`  out  4: column drive, active-low one-hot.
- `clear`  in  1: synchronous clear of `value` and `digit_count`.
- `value`  out  32: entered number; newest digit in [3:0].
- `key_valid`  out  1: one-cycle pulse per accepted key.
- `key_code`  out  4: hex code of the last accepted key; held until the next accepted key.
- `digit_count`  out  4: digits entered since the last clear, saturates at 8.

## Operation
- `row` passes through a 2-flop synchronizer before any use.
- Prescaler counts 0..2^SCAN_BITS-1 and wraps. "Tick" = cycle in which the prescaler is all ones.
- Column index `c` (0..3) advances on each tick and wraps 3->0. `col = ~(4'b0001 << c)`.
- Synchronized rows are sampled on each tick, at the end of the dwell, into a 16-bit frame image. Key (r,c) is pressed when row bit r is low while column c is driven.
- Frame ends on the tick of column 3. Frame result:
  - NONE: no bits set, or two or more bits set (multi-key is ignored).
  - KEY(code): exactly one bit set.
- Key map, by row r, columns 0..3:
  - r0 = 1,2,3,A
  - r1 = 4,5,6,B
  - r2 = 7,8,9,C
  - r3 = 0,F,E,D
- Debounce FSM, evaluated once per frame end:
  - IDLE: on KEY(k), latch cand=k, cnt=1, go to CAND. If DEBOUNCE_SCANS=1, accept immediately and go to HELD.
  - CAND: if KEY(cand), cnt++; when cnt reaches DEBOUNCE_SCANS, accept and go to HELD. If NONE or a different key, go to IDLE with cnt=0.
  - HELD: if NONE, cnt=1 and go to REL. Otherwise stay; a different key is ignored while held.
  - REL: if NONE, cnt++; when cnt reaches DEBOUNCE_SCANS, go to IDLE. Any KEY returns to HELD.
- Accept action: pulse `key_valid`, set `key_code=cand`, set `value = {value[27:0], cand}`, and `digit_count = min(digit_count+1, 8)`. Digits beyond 8 shift out of [31:28].
- `clear` takes priority over accept in the same cycle: `value=0` and `digit_count=0`. `key_valid` and `key_code` still reflect the accept. `clear` does not affect the FSM.

## Timing
- Reset values: `col`=4'b1110, `value`=0, `key_valid`=0, `key_code`=0, `digit_count`=0, FSM=IDLE, prescaler=0, c=0, frame image=0.
- Frame period = 4·2^SCAN_BITS cycles.
- `key_valid`, `value`, `key_code` and `digit_count` update on the clk1 edge following the accepting frame-end tick; all are registered.
- Minimum press-to-`key_valid` latency is DEBOUNCE_SCANS frames plus one cycle, plus synchronizer delay.
- Asserting `rst` mid-press returns to IDLE. A key still held after reset is re-accepted after debounce.
- `clear` acts on the next edge and has no latency dependence on the scan.

## Structure
- Package `keypad_pkg` holds:
  - the FSM state enum (IDLE, CAND, HELD, REL);
  - the 16-entry key-map constant indexed by {r,c};
  - the constants MAX_DIGITS=8 and COLS=4.
- Sub-module `keypad_scan` holds the synchronizer, prescaler, column drive, frame capture and frame result (valid/none/code).
- `keypad_entry` holds the debounce FSM and the entry register.

## Test plan
All scenarios use SCAN_BITS=2 and DEBOUNCE_SCANS=2, giving a 16-cycle frame.
- Reset, no keys: `col` cycles 1110, 1101, 1011, 0111, one step every 4 cycles. `value`=0 and `key_valid` never pulses.
- Press row1/col2 for 5 frames, then release: exactly one `key_valid`, with `key_code`=6, `value`=0x00000006, `digit_count`=1.
- Press-release keys 1,2,3,A,0,F,E,D,9 in order: `value`=0x23A0FED9 and `digit_count`=8 (saturated).
- Hold key 5 for one frame only, and separately bounce key 5 as press/none/press on alternating frames: no `key_valid`.
- Hold keys 4 and 7 together for 4 frames: no accept. Release 7 while 4 stays held: one accept with `key_code`=4.
- Assert `clear` in the same cycle as the accept of key C with `value`=0x12: `key_valid`=1, `key_code`=C, `value`=0, `digit_count`=0. Assert `rst` mid-CAND: all outputs return to reset values.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the hex keypad entry path.
package keypad_pkg;

    // Debounce state machine states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAND = 2'd1,
        HELD = 2'd2,
        REL  = 2'd3
    } kp_state_e;

    localparam int COLS       = 4;
    localparam int MAX_DIGITS = 8;

    // Hex code for each key, indexed by {row, col}; element [0] is row 0 / col 0
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,   // row 3
        4'hC, 4'h9, 4'h8, 4'h7,   // row 2
        4'hB, 4'h6, 4'h5, 4'h4,   // row 1
        4'hA, 4'h3, 4'h2, 4'h1    // row 0
    };

endpackage

// File: rtl/keypad_scan.sv
// Keypad matrix scanner: row synchronizer, column prescaler and drive,
// per-frame key image capture and single-key frame decode.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_BITS = 16
) (
    input  logic       clk1,
    input  logic       rst,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic       frame_end_o,
    output logic       key_hit_o,
    output logic [3:0] key_code_o
);

    logic [3:0]           row_meta_q;
    logic [3:0]           row_sync_q;
    logic [SCAN_BITS-1:0] presc_q;
    logic [SCAN_BITS-1:0] presc_d;
    logic [1:0]           col_idx_q;
    logic [1:0]           col_idx_d;
    logic [15:0]          frame_q;
    logic [15:0]          frame_d;
    logic                 tick;
    logic [4:0]           hit_count;
    logic [3:0]           hit_idx;

    // Two-flop synchronizer; rows idle high through the external pull-ups
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= row_i;
            row_sync_q <= row_meta_q;
        end
    end

    assign tick      = &presc_q;
    assign presc_d   = presc_q + 1'b1;
    assign col_idx_d = tick ? col_idx_q + 2'd1 : col_idx_q;

    // Live image: the column being driven takes the current row sample,
    // every other column keeps what was captured at its own dwell end
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_frame
            assign frame_d[gi] = (col_idx_q == 2'(gi % COLS)) ? ~row_sync_q[gi / COLS]
                                                              : frame_q[gi];
        end
    endgenerate

    // Prescaler, column index and frame image; rows sampled at the end of each dwell
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            col_idx_q <= 2'd0;
            frame_q   <= 16'h0000;
        end else begin
            presc_q   <= presc_d;
            col_idx_q <= col_idx_d;
            if (tick) begin
                frame_q <= frame_d;
            end
        end
    end

    assign col_o       = ~(4'b0001 << col_idx_q);
    assign frame_end_o = tick && (col_idx_q == 2'd3);

    // Count pressed keys in the completed frame and remember where the last one sits
    always_comb begin
        hit_count = 5'd0;
        hit_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_d[i]) begin
                hit_count = hit_count + 5'd1;
                hit_idx   = 4'(i);
            end
        end
    end

    // Multi-key frames are treated like an empty frame
    assign key_hit_o  = (hit_count == 5'd1);
    assign key_code_o = KEY_MAP[hit_idx];

endmodule

// File: rtl/keypad_entry.sv
// Hex keypad entry: debounces scanned frames and shifts each accepted
// digit into a 32-bit value register with a saturating digit count.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_BITS      = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    input  logic        clear,
    output logic [31:0] value,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [3:0]  digit_count
);

    localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

    logic       frame_end;
    logic       frame_hit;
    logic [3:0] frame_code;

    kp_state_e  state_q;
    kp_state_e  state_d;
    logic [3:0] cand_q;
    logic [3:0] cand_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [3:0] cnt_inc;
    logic       accept;

    logic        key_valid_q;
    logic [3:0]  key_code_q;
    logic [31:0] value_q;
    logic [3:0]  digit_count_q;

    keypad_scan #(
        .SCAN_BITS (SCAN_BITS)
    ) u_scan (
        .clk1        (clk1),
        .rst         (rst),
        .row_i       (row),
        .col_o       (col),
        .frame_end_o (frame_end),
        .key_hit_o   (frame_hit),
        .key_code_o  (frame_code)
    );

    // Debounce state register
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cand_q  <= 4'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_inc = cnt_q + 4'd1;

    // Debounce next-state: evaluated only on frame-end ticks
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (frame_hit) begin
                        cand_d  = frame_code;
                        cnt_d   = 4'd1;
                        state_d = (DB_N == 4'd1) ? HELD : CAND;
                    end
                end
                CAND: begin
                    if (frame_hit && (frame_code == cand_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DB_N) begin
                            state_d = HELD;
                        end
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    // A single empty frame already satisfies a one-frame release
                    if (!frame_hit) begin
                        cnt_d   = (DB_N == 4'd1) ? 4'd0 : 4'd1;
                        state_d = (DB_N == 4'd1) ? IDLE : REL;
                    end
                end
                REL: begin
                    if (!frame_hit) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DB_N) begin
                            cnt_d   = 4'd0;
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Accept whenever a press debounce completes (entry into HELD from IDLE or CAND)
    always_comb begin
        accept = 1'b0;
        if (frame_end && (state_d == HELD) && ((state_q == IDLE) || (state_q == CAND))) begin
            accept = 1'b1;
        end
    end

    // Entry register: clear wins over an accepted digit, key report is unaffected by clear
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            key_valid_q   <= 1'b0;
            key_code_q    <= 4'd0;
            value_q       <= 32'd0;
            digit_count_q <= 4'd0;
        end else begin
            key_valid_q <= accept;
            if (accept) begin
                key_code_q <= cand_d;
            end
            if (clear) begin
                value_q       <= 32'd0;
                digit_count_q <= 4'd0;
            end else if (accept) begin
                value_q <= {value_q[27:0], cand_d};
                if (digit_count_q < 4'(MAX_DIGITS)) begin
                    digit_count_q <= digit_count_q + 4'd1;
                end
            end
        end
    end

    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign value       = value_q;
    assign digit_count = digit_count_q;

endmodule
